branch_flag_unit: RTL and testbench
===================================

Name: branch_flag_unit

Overview:
- Sits directly downstream of alu_wrapper in the execute stage.
- Captures the 2-bit ALU flags produced by CMP into an architectural flag register.
- Resolves the conditional branches BEQ/BNE/BLT/BGT against that register, issues a registered PC redirect, and holds a wrong-path flush window.
- Keeps a shadow copy of the flags across interrupt entry, restored on RETI.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays high after a taken branch (legal range 1..7).
- PC_W, 32: width of the PC and target buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  ex_opcode/alu_flags/br_target are valid this cycle.
- ex_opcode  in  5  opcode of the instruction in execute.
- alu_flags  in  2  ALU flags: bit1 = N (a<b signed), bit0 = Z (a==b).
- br_target  in  PC_W  precomputed branch target.
- int_entry  in  1  one-cycle pulse from the controller on interrupt acceptance.
- flags_q  out  2  architectural flag register {N,Z}.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  PC_W  target for redirect; holds its last value otherwise.
- flush  out  1  squash younger instructions.

Behaviour:
- Opcodes (decided here): CMP 10010, BEQ 10011, BNE 10100, BLT 10101, BGT 10110, RETI 11011. All other opcodes are ignored.
- Reset (async, any state): flags_q=0, shadow=0, redirect=0, redirect_pc=0, flush=0, state=RUN, flush counter=0.
- FSM states:
  - RUN: normal operation.
  - FLUSH: counter loaded with FLUSH_CYCLES-1; decrements each cycle; returns to RUN on the cycle the counter reads 0.
  - flush is 1 in every FLUSH cycle.
- In RUN, for an accepted instruction (ex_valid=1):
  - CMP at cycle n: flags_q=alu_flags at edge n+1.
  - Branch conditions, evaluated on flags_q (not alu_flags): BEQ taken if Z; BNE if !Z; BLT if N; BGT if !N && !Z.
  - Taken branch at cycle n:
    - redirect=1 and redirect_pc=br_target during cycle n+1 only.
    - State goes to FLUSH at n+1, so flush is high for cycles n+1 .. n+FLUSH_CYCLES.
  - Not-taken branch: no outputs change.
  - RETI: flags_q=shadow at the next edge.
- In FLUSH, ex_valid is ignored: no flag update, no branch, no RETI restore (wrong path). int_entry is still honoured.
- int_entry at cycle n: shadow gets the value flags_q will hold after edge n+1.
  - If an accepted CMP is in the same cycle, shadow captures the new CMP flags.
- int_entry together with an accepted RETI:
  - flags_q=old shadow.
  - shadow=old flags_q.
- Back-to-back CMP then branch on consecutive cycles is legal: the branch sees the updated flags_q.
- Flags are only ever written by CMP and RETI.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count[15:0] and br_taken_count[15:0].
  - Both reset to 0 and are incremented on each accepted branch / taken branch respectively.
  - Both saturate at 16'hFFFF.
  - Neither counts in FLUSH.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then CMP with alu_flags=2'b01, then BEQ with br_target=32'h0000_0040 next cycle -> flags_q=01; redirect pulse 1 cycle with redirect_pc=32'h40; flush high exactly 2 cycles.
- CMP flags=2'b10, then BGT -> not taken, redirect/flush stay 0. Then BLT -> taken.
- Taken BNE immediately followed by CMP flags=2'b11 and a BEQ inside the flush window -> flags_q unchanged, no second redirect.
- CMP flags=2'b10, int_entry pulse, CMP flags=2'b01, RETI -> flags_q returns to 10.
- Assert rst_n=0 mid-FLUSH -> flush, redirect, flags_q drop to 0 immediately (asynchronously); RUN after release.
- BRANCH_STATS_EN defined: 3 branches, 2 taken -> br_count=3, br_taken_count=2. Force 16'hFFFF, then another branch -> stays 16'hFFFF.

Source files
------------

// File: rtl/branch_flag_unit.sv
// ============================================================================
// Module      : branch_flag_unit
// Description : Execute-stage CMP flag register, BEQ/BNE/BLT/BGT resolution,
//               registered PC redirect, wrong-path flush window and interrupt
//               flag shadow. Optional branch statistics: BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_flag_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [4:0]      ex_opcode,
    input  logic [1:0]      alu_flags,
    input  logic [PC_W-1:0] br_target,
    input  logic            int_entry,
    output logic [1:0]      flags_q,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     br_taken_count
`endif
);

    localparam logic [4:0] c_op_cmp  = 5'b10010;
    localparam logic [4:0] c_op_beq  = 5'b10011;
    localparam logic [4:0] c_op_bne  = 5'b10100;
    localparam logic [4:0] c_op_blt  = 5'b10101;
    localparam logic [4:0] c_op_bgt  = 5'b10110;
    localparam logic [4:0] c_op_reti = 5'b11011;
    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    logic [1:0] r_shadow;
    logic [1:0] w_flags_nxt;
    logic [1:0] w_shadow_nxt;
    logic       w_accept;
    logic       w_is_branch;
    logic       w_cond;
    logic       w_taken;

    // Instructions presented during the flush window are wrong-path.
    assign w_accept = ex_valid && (r_state == ST_RUN);

    always_comb begin
        w_is_branch = 1'b0;
        w_cond      = 1'b0;
        case (ex_opcode)
            c_op_beq: begin w_is_branch = 1'b1; w_cond = flags_q[0];                 end
            c_op_bne: begin w_is_branch = 1'b1; w_cond = !flags_q[0];                end
            c_op_blt: begin w_is_branch = 1'b1; w_cond = flags_q[1];                 end
            c_op_bgt: begin w_is_branch = 1'b1; w_cond = !flags_q[1] && !flags_q[0]; end
            default:  begin w_is_branch = 1'b0; w_cond = 1'b0;                       end
        endcase
    end

    assign w_taken = w_accept && w_is_branch && w_cond;

    always_comb begin
        w_flags_nxt  = flags_q;
        w_shadow_nxt = r_shadow;
        if (w_accept && (ex_opcode == c_op_cmp)) begin
            w_flags_nxt = alu_flags;
        end else if (w_accept && (ex_opcode == c_op_reti)) begin
            w_flags_nxt = r_shadow;
        end
        // Interrupt entry coinciding with RETI swaps the live and shadow flags.
        if (int_entry) begin
            if (w_accept && (ex_opcode == c_op_reti)) begin
                w_shadow_nxt = flags_q;
            end else begin
                w_shadow_nxt = w_flags_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= 2'b00;
            r_shadow    <= 2'b00;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flags_q  <= w_flags_nxt;
            r_shadow <= w_shadow_nxt;
            redirect <= w_taken;
            if (w_taken) begin
                redirect_pc <= br_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        flush       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_taken) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = c_flush_load;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count       <= 16'd0;
            br_taken_count <= 16'd0;
        end else begin
            if (w_accept && w_is_branch && (br_count != 16'hFFFF)) begin
                br_count <= br_count + 16'd1;
            end
            if (w_taken && (br_taken_count != 16'hFFFF)) begin
                br_taken_count <= br_taken_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_flag_unit.sv
// Testbench for branch_flag_unit: directed vector table, randomized run against
// a cycle-indexed reference model, asynchronous reset and optional statistics.
`default_nettype none

module tb_branch_flag_unit;

    localparam int FC = 2;

    localparam logic [4:0] CMP  = 5'b10010;
    localparam logic [4:0] BEQ  = 5'b10011;
    localparam logic [4:0] BNE  = 5'b10100;
    localparam logic [4:0] BLT  = 5'b10101;
    localparam logic [4:0] BGT  = 5'b10110;
    localparam logic [4:0] RETI = 5'b11011;
    localparam logic [4:0] NOP  = 5'b00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic [1:0]  alu_flags;
    logic [31:0] br_target;
    logic        int_entry;
    logic [1:0]  flags_q;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] br_taken_count;
`endif

    branch_flag_unit #(.FLUSH_CYCLES(FC), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .alu_flags   (alu_flags),
        .br_target   (br_target),
        .int_entry   (int_entry),
        .flags_q     (flags_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush)
`ifdef BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: architectural state plus absolute cycle bookkeeping.
    int          cyc;
    int          flush_end;
    logic [1:0]  m_flags;
    logic [1:0]  m_shadow;
    logic        m_red;
    logic [31:0] m_pc;
    logic [15:0] m_br;
    logic [15:0] m_tk;

    typedef struct {
        logic        v;
        logic [4:0]  op;
        logic [1:0]  f;
        logic [31:0] t;
        logic        ie;
        logic [1:0]  ef;
        logic        er;
        logic [31:0] epc;
        logic        efl;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic v, input logic [4:0] op, input logic [1:0] f,
                                input logic [31:0] t, input logic ie, input logic [1:0] ef,
                                input logic er, input logic [31:0] epc, input logic efl);
        vec_t r;
        r.v = v; r.op = op; r.f = f; r.t = t; r.ie = ie;
        r.ef = ef; r.er = er; r.epc = epc; r.efl = efl;
        return r;
    endfunction

    task automatic model_reset();
        cyc = 0; flush_end = 0;
        m_flags = 2'b00; m_shadow = 2'b00; m_red = 1'b0; m_pc = 32'h0;
        m_br = 16'h0; m_tk = 16'h0;
    endtask

    task automatic check(input string nm, input logic [1:0] ef, input logic er,
                         input logic [31:0] epc, input logic efl);
        logic bad;
        vectors++;
        bad = (flags_q !== ef) || (redirect !== er) || (redirect_pc !== epc) || (flush !== efl);
`ifdef BRANCH_STATS_EN
        bad = bad || (br_count !== m_br) || (br_taken_count !== m_tk);
        if (bad)
            $display("FAIL %s: stats got br=%h tk=%h want br=%h tk=%h", nm,
                     br_count, br_taken_count, m_br, m_tk);
`endif
        if (bad) begin
            miscompares++;
            $display("FAIL %s @cyc%0d: got flags=%b red=%b pc=%h flush=%b, want flags=%b red=%b pc=%h flush=%b",
                     nm, cyc, flags_q, redirect, redirect_pc, flush, ef, er, epc, efl);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, sample at +1.
    task automatic step(input logic v, input logic [4:0] op, input logic [1:0] f,
                        input logic [31:0] t, input logic ie);
        logic       acc, taken, is_br, cond;
        logic [1:0] nf;
        ex_valid = v; ex_opcode = op; alu_flags = f; br_target = t; int_entry = ie;
        acc   = v && (cyc >= flush_end);
        is_br = (op == BEQ) || (op == BNE) || (op == BLT) || (op == BGT);
        cond  = (op == BEQ) ? (m_flags == 2'b01 || m_flags == 2'b11) :
                (op == BNE) ? !(m_flags == 2'b01 || m_flags == 2'b11) :
                (op == BLT) ? (m_flags >= 2'b10) :
                (op == BGT) ? (m_flags == 2'b00) : 1'b0;
        taken = acc && is_br && cond;
        nf = (acc && op == CMP) ? f : (acc && op == RETI) ? m_shadow : m_flags;
        if (ie) m_shadow = (acc && op == RETI) ? m_flags : nf;
        m_flags = nf;
        m_red = taken;
        if (taken) begin
            m_pc = t;
            flush_end = cyc + FC + 1;
        end
        if (acc && is_br && m_br != 16'hFFFF) m_br = m_br + 16'd1;
        if (taken && m_tk != 16'hFFFF) m_tk = m_tk + 16'd1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_opcode = NOP; alu_flags = 2'b00; br_target = 32'h0; int_entry = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("reset", 2'b00, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        tbl[0]  = mk(1, CMP,  2'b01, 32'h0,   0, 2'b01, 0, 32'h0,   0);
        tbl[1]  = mk(1, BEQ,  2'b00, 32'h40,  0, 2'b01, 1, 32'h40,  1);
        tbl[2]  = mk(0, NOP,  2'b00, 32'h0,   0, 2'b01, 0, 32'h40,  1);
        tbl[3]  = mk(0, NOP,  2'b00, 32'h0,   0, 2'b01, 0, 32'h40,  0);
        tbl[4]  = mk(1, CMP,  2'b10, 32'h0,   0, 2'b10, 0, 32'h40,  0);
        tbl[5]  = mk(1, BGT,  2'b00, 32'h80,  0, 2'b10, 0, 32'h40,  0);
        tbl[6]  = mk(1, BLT,  2'b00, 32'h100, 0, 2'b10, 1, 32'h100, 1);
        tbl[7]  = mk(0, NOP,  2'b00, 32'h0,   0, 2'b10, 0, 32'h100, 1);
        tbl[8]  = mk(0, NOP,  2'b00, 32'h0,   0, 2'b10, 0, 32'h100, 0);
        tbl[9]  = mk(1, BNE,  2'b00, 32'h200, 0, 2'b10, 1, 32'h200, 1);
        tbl[10] = mk(1, CMP,  2'b11, 32'h0,   0, 2'b10, 0, 32'h200, 1);
        tbl[11] = mk(1, BEQ,  2'b00, 32'h300, 0, 2'b10, 0, 32'h200, 0);
        tbl[12] = mk(0, NOP,  2'b00, 32'h0,   0, 2'b10, 0, 32'h200, 0);
        tbl[13] = mk(1, CMP,  2'b10, 32'h0,   0, 2'b10, 0, 32'h200, 0);
        tbl[14] = mk(0, NOP,  2'b00, 32'h0,   1, 2'b10, 0, 32'h200, 0);
        tbl[15] = mk(1, CMP,  2'b01, 32'h0,   0, 2'b01, 0, 32'h200, 0);
        tbl[16] = mk(1, RETI, 2'b00, 32'h0,   0, 2'b10, 0, 32'h200, 0);
        tbl[17] = mk(1, CMP,  2'b11, 32'h0,   0, 2'b11, 0, 32'h200, 0);
        tbl[18] = mk(1, RETI, 2'b00, 32'h0,   1, 2'b10, 0, 32'h200, 0);
        tbl[19] = mk(1, RETI, 2'b00, 32'h0,   0, 2'b11, 0, 32'h200, 0);
        tbl[20] = mk(1, CMP,  2'b00, 32'h0,   1, 2'b00, 0, 32'h200, 0);
        tbl[21] = mk(1, CMP,  2'b11, 32'h0,   0, 2'b11, 0, 32'h200, 0);
        tbl[22] = mk(1, RETI, 2'b00, 32'h0,   0, 2'b00, 0, 32'h200, 0);

        do_reset();

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].v, tbl[i].op, tbl[i].f, tbl[i].t, tbl[i].ie);
            check($sformatf("table[%0d]", i), tbl[i].ef, tbl[i].er, tbl[i].epc, tbl[i].efl);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            case ($urandom_range(0, 7))
                0: op = CMP;  1: op = BEQ;  2: op = BNE;  3: op = BLT;
                4: op = BGT;  5: op = RETI; 6: op = NOP;
                default: op = 5'($urandom);
            endcase
            step(1'($urandom_range(0, 3) != 0), op, 2'($urandom), $urandom,
                 1'($urandom_range(0, 7) == 0));
            check("random", m_flags, m_red, m_pc, cyc < flush_end);
        end

        // Asynchronous reset in the middle of a flush window.
        step(1, CMP, 2'b01, 32'h0, 0);
        check("pre_rst_cmp", m_flags, m_red, m_pc, cyc < flush_end);
        step(1, BEQ, 2'b00, 32'hABC0, 0);
        check("pre_rst_beq", 2'b01, 1'b1, 32'hABC0, 1'b1);
        ex_valid = 1'b0; ex_opcode = NOP; int_entry = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_rst", 2'b00, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, NOP, 2'b00, 32'h0, 0);
        check("post_rst_run", 2'b00, 1'b0, 32'h0, 1'b0);
        step(1, BGT, 2'b00, 32'h44, 0);
        check("post_rst_bgt", 2'b00, 1'b1, 32'h44, 1'b1);
        step(0, NOP, 2'b00, 32'h0, 0);
        step(0, NOP, 2'b00, 32'h0, 0);
        check("post_rst_idle", 2'b00, 1'b0, 32'h44, 1'b0);

`ifdef BRANCH_STATS_EN
        do_reset();
        step(1, CMP, 2'b01, 32'h0, 0);
        step(1, BEQ, 2'b00, 32'h10, 0);
        step(0, NOP, 2'b00, 32'h0, 0);
        step(0, NOP, 2'b00, 32'h0, 0);
        step(1, BNE, 2'b00, 32'h20, 0);
        step(1, BEQ, 2'b00, 32'h30, 0);
        step(0, NOP, 2'b00, 32'h0, 0);
        step(0, NOP, 2'b00, 32'h0, 0);
        vectors++;
        if (br_count !== 16'd3 || br_taken_count !== 16'd2) begin
            miscompares++;
            $display("FAIL stats_3_2: got br=%0d tk=%0d, want br=3 tk=2", br_count, br_taken_count);
        end
        for (int i = 0; i < 65533; i++) step(1, BNE, 2'b00, 32'h0, 0);
        vectors++;
        if (br_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stats_reach_max: got br=%h, want br=ffff", br_count);
        end
        step(1, BNE, 2'b00, 32'h0, 0);
        vectors++;
        if (br_count !== 16'hFFFF || br_taken_count !== 16'd2) begin
            miscompares++;
            $display("FAIL stats_saturate: got br=%h tk=%0d, want br=ffff tk=2", br_count, br_taken_count);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
